// File: rtl/ip_filter_cam_arb.sv
// ip_filter_cam_arb
//   Small filter table (CAM) with one config write port and two lookup
//   requesters sharing a single-ported match path. A 1-bit round-robin
//   pointer picks between the requesters when both are eligible; config
//   writes have strict priority and block every lookup grant while asserted.
//   Each requester has one response register (latency 1 from grant) that is
//   held until consumed, so at most one lookup per requester is in flight.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   cfg_wr_*                entry write {entry_val, tag, data} at cfg_wr_idx
//   cfg_wr_rdy              always 1
//   lkupN_req_val/tag/rdy   lookup request handshake, N = 0,1
//   lkupN_resp_val/hit/data lookup result (data is 0 on a miss)
//   lkupN_resp_rdy          requester N consumes its result
module ip_filter_cam_arb #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 8,
  parameter int DATA_W      = 1,
  localparam int IDX_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cfg_wr_val,
  input  logic [IDX_W-1:0]  cfg_wr_idx,
  input  logic              cfg_wr_entry_val,
  input  logic [TAG_W-1:0]  cfg_wr_tag,
  input  logic [DATA_W-1:0] cfg_wr_data,
  output logic              cfg_wr_rdy,

  input  logic              lkup0_req_val,
  input  logic [TAG_W-1:0]  lkup0_req_tag,
  output logic              lkup0_req_rdy,
  output logic              lkup0_resp_val,
  output logic              lkup0_resp_hit,
  output logic [DATA_W-1:0] lkup0_resp_data,
  input  logic              lkup0_resp_rdy,

  input  logic              lkup1_req_val,
  input  logic [TAG_W-1:0]  lkup1_req_tag,
  output logic              lkup1_req_rdy,
  output logic              lkup1_resp_val,
  output logic              lkup1_resp_hit,
  output logic [DATA_W-1:0] lkup1_resp_data,
  input  logic              lkup1_resp_rdy
);

  logic              r_ent_val  [NUM_ENTRIES];
  logic [TAG_W-1:0]  r_ent_tag  [NUM_ENTRIES];
  logic [DATA_W-1:0] r_ent_data [NUM_ENTRIES];

  logic              r_rr_ptr;
  logic              r_resp_val0, r_resp_hit0;
  logic [DATA_W-1:0] r_resp_data0;
  logic              r_resp_val1, r_resp_hit1;
  logic [DATA_W-1:0] r_resp_data1;

  logic              w_elig0, w_elig1;
  logic              w_gnt0, w_gnt1;
  logic [TAG_W-1:0]  w_lkup_tag;
  logic              w_hit;
  logic [DATA_W-1:0] w_data;

  assign cfg_wr_rdy = 1'b1;

  // A requester with an unconsumed response is not eligible, which also
  // keeps it from being re-granted on the edge that consumes that response.
  // rst_n gates the grants so rdy stays low throughout reset.
  always_comb begin
    w_elig0 = lkup0_req_val & ~r_resp_val0;
    w_elig1 = lkup1_req_val & ~r_resp_val1;
    w_gnt0  = rst_n & ~cfg_wr_val & w_elig0 & (~w_elig1 | ~r_rr_ptr);
    w_gnt1  = rst_n & ~cfg_wr_val & w_elig1 & (~w_elig0 |  r_rr_ptr);
  end

  assign lkup0_req_rdy = w_gnt0;
  assign lkup1_req_rdy = w_gnt1;

  assign w_lkup_tag = w_gnt1 ? lkup1_req_tag : lkup0_req_tag;

  // Scan from the top down so the lowest matching index is the one that sticks.
  always_comb begin
    w_hit  = 1'b0;
    w_data = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (r_ent_val[i] && (r_ent_tag[i] == w_lkup_tag)) begin
        w_hit  = 1'b1;
        w_data = r_ent_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_ent_val[i]  <= 1'b0;
        r_ent_tag[i]  <= '0;
        r_ent_data[i] <= '0;
      end
    end else begin
      // Compare against each index so an out-of-range cfg_wr_idx is ignored.
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (cfg_wr_val && (IDX_W'(i) == cfg_wr_idx)) begin
          r_ent_val[i]  <= cfg_wr_entry_val;
          r_ent_tag[i]  <= cfg_wr_tag;
          r_ent_data[i] <= cfg_wr_data;
        end
      end
    end
  end

  // After a grant the pointer moves to the requester that was not served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 1'b0;
    end else if (w_gnt0) begin
      r_rr_ptr <= 1'b1;
    end else if (w_gnt1) begin
      r_rr_ptr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_val0  <= 1'b0;
      r_resp_hit0  <= 1'b0;
      r_resp_data0 <= '0;
    end else if (w_gnt0) begin
      r_resp_val0  <= 1'b1;
      r_resp_hit0  <= w_hit;
      r_resp_data0 <= w_data;
    end else if (r_resp_val0 && lkup0_resp_rdy) begin
      r_resp_val0  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_val1  <= 1'b0;
      r_resp_hit1  <= 1'b0;
      r_resp_data1 <= '0;
    end else if (w_gnt1) begin
      r_resp_val1  <= 1'b1;
      r_resp_hit1  <= w_hit;
      r_resp_data1 <= w_data;
    end else if (r_resp_val1 && lkup1_resp_rdy) begin
      r_resp_val1  <= 1'b0;
    end
  end

  assign lkup0_resp_val  = r_resp_val0;
  assign lkup0_resp_hit  = r_resp_hit0;
  assign lkup0_resp_data = r_resp_data0;
  assign lkup1_resp_val  = r_resp_val1;
  assign lkup1_resp_hit  = r_resp_hit1;
  assign lkup1_resp_data = r_resp_data1;

endmodule
